uart_rx_fifo: RTL and testbench

Second-generation UART receiver with a run-time baud divisor, compile-time frame format, per-word error flags and a parametrised receive FIFO with valid/ready drain. It sits between the async serial pin and any streaming consumer (command parser, bus bridge). It supersedes the fixed-rate, single-register receiver for all new designs.

---
 rtl/uart_rx_fifo.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop sync, majority-vote bit sampling, per-word pe/fe/brk flags, valid/ready FIFO.
// Optional character timeout is built only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_fifo #(
    parameter int P_NUM_BITS   = 8,
    parameter int P_NUM_STOP   = 1,
    parameter int P_PARITY     = 0,
    parameter int P_FIFO_DEPTH = 16,
    parameter int P_DIV_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            uart_rx,
    input  logic [P_DIV_WIDTH-1:0]          baud_div,
    output logic [P_NUM_BITS-1:0]           m_data,
    output logic                            m_pe,
    output logic                            m_fe,
    output logic                            m_brk,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [$clog2(P_FIFO_DEPTH):0]   fifo_level,
    output logic                            overrun,
    input  logic                            overrun_clr,
    output logic                            rx_timeout
);
    localparam int AW = $clog2(P_FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = P_NUM_BITS + 3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_PUSH   = 3'd5;

    logic                   rx_meta, rx_s, rx_prev;
    logic [2:0]             state;
    logic [P_DIV_WIDTH-1:0] cnt, d_lat, d_eff, h, q;
    logic [3:0]             bit_idx;
    logic [2:0]             samp;
    logic [P_NUM_BITS-1:0]  shreg;
    logic                   par_bit, pe, fe, brk;
    logic                   start_det, bit_end, vote;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign d_eff     = (baud_div < P_DIV_WIDTH'(16)) ? P_DIV_WIDTH'(16) : baud_div;
    assign h         = d_lat >> 1;
    assign q         = d_lat >> 3;
    assign start_det = (state == S_IDLE) && rx_prev && !rx_s;
    assign bit_end   = (cnt == d_lat - P_DIV_WIDTH'(1));
    assign vote      = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            d_lat   <= P_DIV_WIDTH'(16);
            bit_idx <= '0;
            samp    <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            pe      <= 1'b0;
            fe      <= 1'b0;
        end else begin
            if (state != S_IDLE && state != S_PUSH) begin
                cnt <= bit_end ? '0 : cnt + P_DIV_WIDTH'(1);
                if (cnt == h - q) samp[0] <= rx_s;
                if (cnt == h)     samp[1] <= rx_s;
                if (cnt == h + q) samp[2] <= rx_s;
            end
            case (state)
                S_IDLE: if (start_det) begin
                    state   <= S_START;
                    cnt     <= '0;
                    d_lat   <= d_eff;
                    bit_idx <= '0;
                    pe      <= 1'b0;
                    fe      <= 1'b0;
                    par_bit <= 1'b0;
                end
                S_START: if (bit_end) state <= vote ? S_IDLE : S_DATA;
                S_DATA: if (bit_end) begin
                    shreg <= {vote, shreg[P_NUM_BITS-1:1]};
                    if (bit_idx == 4'(P_NUM_BITS - 1)) begin
                        bit_idx <= '0;
                        state   <= (P_PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                    end
                end
                S_PARITY: if (bit_end) begin
                    par_bit <= vote;
                    pe      <= (P_PARITY == 2) ? ~(^shreg ^ vote) : (^shreg ^ vote);
                    state   <= S_STOP;
                end
                S_STOP: if (bit_end) begin
                    if (!vote) fe <= 1'b1;
                    if (bit_idx == 4'(P_NUM_STOP - 1)) begin
                        bit_idx <= '0;
                        state   <= S_PUSH;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                    end
                end
                S_PUSH:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Break: all-zero data and parity with a bad stop bit.
    assign brk = (shreg == '0) && ((P_PARITY == 0) || !par_bit) && fe;

    logic [WW-1:0] mem [P_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          push, pop, full, push_en;
    logic [WW-1:0] head;

    assign push    = (state == S_PUSH);
    assign pop     = m_valid && m_ready;
    assign full    = (level == LW'(P_FIFO_DEPTH));
    assign push_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= {brk, fe, pe, shreg};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_en, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            // A new drop wins over a same-cycle clear.
            if (push && full && !pop) overrun <= 1'b1;
            else if (overrun_clr)     overrun <= 1'b0;
        end
    end

    assign head       = mem[rd_ptr];
    assign m_valid    = (level != '0);
    assign fifo_level = level;
    assign m_data     = m_valid ? head[P_NUM_BITS-1:0] : '0;
    assign m_pe       = m_valid && head[P_NUM_BITS];
    assign m_fe       = m_valid && head[P_NUM_BITS+1];
    assign m_brk      = m_valid && head[P_NUM_BITS+2];

`ifdef UART_RX_TIMEOUT_EN
    logic [P_DIV_WIDTH-1:0] tmo_clk;
    logic [5:0]             tmo_bits;
    logic                   tmo_q;

    // Idle time counted in bit-times of the last latched divisor, saturating at 40.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_clk  <= '0;
            tmo_bits <= '0;
            tmo_q    <= 1'b0;
        end else begin
            if (push || pop || start_det) begin
                tmo_clk  <= '0;
                tmo_bits <= '0;
            end else if (state == S_IDLE && m_valid && tmo_bits != 6'd40) begin
                if (tmo_clk == d_lat - P_DIV_WIDTH'(1)) begin
                    tmo_clk  <= '0;
                    tmo_bits <= tmo_bits + 6'd1;
                end else begin
                    tmo_clk <= tmo_clk + P_DIV_WIDTH'(1);
                end
            end
            tmo_q <= m_valid && (state == S_IDLE) && (tmo_bits == 6'd40) && !pop && !start_det;
        end
    end
    assign rx_timeout = tmo_q;
`else
    assign rx_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: default 8N1 receiver (depth 16) and an odd-parity receiver (depth 4) on separate lines.
module tb_uart_rx_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic        rx0, rx1;
    logic [15:0] baud_div;
    logic        rdy0, rdy1, clr0, clr1;

    logic [7:0] data0, data1;
    logic       pe0, fe0, brk0, vld0, ovr0, tmo0;
    logic       pe1, fe1, brk1, vld1, ovr1, tmo1;
    logic [4:0] lvl0;
    logic [2:0] lvl1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    uart_rx_fifo dut (
        .clk(clk), .rst(rst), .uart_rx(rx0), .baud_div(baud_div),
        .m_data(data0), .m_pe(pe0), .m_fe(fe0), .m_brk(brk0), .m_valid(vld0),
        .m_ready(rdy0), .fifo_level(lvl0), .overrun(ovr0), .overrun_clr(clr0),
        .rx_timeout(tmo0)
    );

    uart_rx_fifo #(.P_PARITY(2), .P_FIFO_DEPTH(4)) dut_p (
        .clk(clk), .rst(rst), .uart_rx(rx1), .baud_div(baud_div),
        .m_data(data1), .m_pe(pe1), .m_fe(fe1), .m_brk(brk1), .m_valid(vld1),
        .m_ready(rdy1), .fifo_level(lvl1), .overrun(ovr1), .overrun_clr(clr1),
        .rx_timeout(tmo1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bits go out LSB first, each held bclk cycles.
    task automatic send_bits(input int ln, input logic [15:0] bits, input int n, input int bclk);
        for (int i = 0; i < n; i++) begin
            if (ln == 0) rx0 = bits[i];
            else         rx1 = bits[i];
            wait_clk(bclk);
        end
    endtask

    task automatic pop0();
        rdy0 = 1'b1;
        @(posedge clk);
        #1 rdy0 = 1'b0;
    endtask

    task automatic pop1();
        rdy1 = 1'b1;
        @(posedge clk);
        #1 rdy1 = 1'b0;
    endtask

    initial begin
        logic [7:0] bv;
        rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; baud_div = 16'd16;
        rdy0 = 1'b0; rdy1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(1);

        chk("rst_valid", vld0, 0);
        chk("rst_level", lvl0, 0);
        chk("rst_overrun", ovr0, 0);
        chk("rst_timeout", tmo0, 0);
        chk("rst_flags", {pe0, fe0, brk0}, 0);
        chk("rst_data", data0, 0);

        // 0xA5 8N1: m_valid rises exactly 4 cycles after the line's stop bit ends.
        send_bits(0, {1'b1, 8'hA5, 1'b0}, 10, 16);
        wait_clk(3);
        chk("a5_not_yet", vld0, 0);
        wait_clk(1);
        chk("a5_valid", vld0, 1);
        chk("a5_data", data0, 8'hA5);
        chk("a5_flags", {pe0, fe0, brk0}, 0);
        chk("a5_level", lvl0, 1);
        pop0();
        chk("a5_popped", lvl0, 0);

        // Divisor below 16 behaves as 16.
        baud_div = 16'd5;
        send_bits(0, {1'b1, 8'h3C, 1'b0}, 10, 16);
        wait_clk(6);
        chk("div_min_data", data0, 8'h3C);
        pop0();
        baud_div = 16'd16;

        // 3-cycle glitch is a false start.
        rx0 = 1'b0;
        wait_clk(3);
        rx0 = 1'b1;
        wait_clk(40);
        chk("glitch_level", lvl0, 0);

        // Low stop bit on 0x55.
        send_bits(0, {1'b0, 8'h55, 1'b0}, 10, 16);
        rx0 = 1'b1;
        wait_clk(6);
        chk("fe_data", data0, 8'h55);
        chk("fe_flags", {brk0, fe0, pe0}, 3'b010);
        pop0();

        // Line low 12 bit-times: one break word only.
        rx0 = 1'b0;
        wait_clk(192);
        rx0 = 1'b1;
        wait_clk(40);
        chk("brk_level", lvl0, 1);
        chk("brk_data", data0, 0);
        chk("brk_flags", {brk0, fe0, pe0}, 3'b110);
        pop0();

        // Reset in mid-frame discards it.
        rx0 = 1'b0;
        wait_clk(40);
        rst = 1'b1;
        wait_clk(2);
        rx0 = 1'b1;
        rst = 1'b0;
        wait_clk(200);
        chk("midrst_level", lvl0, 0);

        // Overrun: 17 frames with no pops.
        for (int i = 0; i <= 16; i++) begin
            bv = 8'(i);
            send_bits(0, {1'b1, bv, 1'b0}, 10, 16);
            wait_clk(16);
        end
        chk("ovr_level", lvl0, 16);
        chk("ovr_flag", ovr0, 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), data0, 32'(i));
            pop0();
        end
        chk("drain_empty", vld0, 0);
        chk("ovr_sticky", ovr0, 1);
        clr0 = 1'b1;
        wait_clk(1);
        clr0 = 1'b0;
        chk("ovr_cleared", ovr0, 0);

        // Odd parity: 0x3C has four ones, so parity bit 1 is correct and 0 is wrong.
        send_bits(1, {1'b1, 1'b1, 8'h3C, 1'b0}, 11, 16);
        wait_clk(16);
        send_bits(1, {1'b1, 1'b0, 8'h3C, 1'b0}, 11, 16);
        wait_clk(6);
        chk("par_level", lvl1, 2);
        chk("par_ok_data", data1, 8'h3C);
        chk("par_ok_flags", {brk1, fe1, pe1}, 3'b000);
        pop1();
        chk("par_bad_data", data1, 8'h3C);
        chk("par_bad_flags", {brk1, fe1, pe1}, 3'b001);
        pop1();
        chk("par_empty", {vld1, lvl1}, 0);
        chk("par_status", {ovr1, tmo1}, 0);

`ifdef UART_RX_TIMEOUT_EN
        baud_div = 16'd20;
        send_bits(0, {1'b1, 8'h77, 1'b0}, 10, 20);
        wait_clk(780);
        chk("tmo_early", tmo0, 0);
        wait_clk(40);
        chk("tmo_set", tmo0, 1);
        pop0();
        chk("tmo_clear", tmo0, 0);
`else
        chk("tmo_tied", tmo0, 0);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
